imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate/output width; legal values 32 and 64.
REQ-002 Parameter INST_W, default 25, instruction field width; carries instr[31:7], so inst[24] = instr[31].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discards all held entries on the next edge.
REQ-006 in_valid  input  1  upstream offers inst/imm_src.
REQ-007 in_ready  output  1  block can accept; registered, equals !skid_valid.
REQ-008 inst  input  INST_W  instruction bits [31:7].
REQ-009 imm_src  input  3  format select.
REQ-010 out_valid  output  1  imm_ext/err hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 imm_ext  output  XLEN  extended immediate.
REQ-013 err  output  1  result came from an illegal imm_src; qualified by out_valid.

Function
REQ-014 Formats (all sign-extend from inst[24] to XLEN unless noted):
- 000 I: inst[24:13].
- 001 S: {inst[24:18], inst[4:0]}.
- 010 B: {inst[24], inst[0], inst[23:18], inst[4:1], 1'b0}.
- 011 U: {inst[24:5], 12'b0}.
- 100 J: {inst[24], inst[12:5], inst[13], inst[23:14], 1'b0}.
REQ-015 More formats:
- 101 CSR uimm: inst[12:8], zero-extended.
- 110 shamt: inst[17:13] when XLEN=32 and inst[18:13] when XLEN=64, zero-extended.
- 111: imm_ext = 0, err = 1.
REQ-016 Transfers occur on valid && ready at each port; data is never dropped or duplicated outside flush/reset.
REQ-017 Latency: an input accepted in cycle N appears with out_valid=1 in cycle N+1 when the output register is empty or drains in cycle N.
REQ-018 Storage is one output register plus one skid register.
REQ-019 Ordering is strict FIFO.
REQ-020 While out_valid && !out_ready, imm_ext and err hold stable.
REQ-021 Output stalled and input accepted: the entry goes to skid.
REQ-022 in_ready deasserts the cycle after skid fills and reasserts the cycle after skid drains into the output register.
REQ-023 Simultaneous output drain and input accept with skid empty: the output register loads the new entry, so out_valid stays 1.
REQ-024 Simultaneous output drain with skid full: skid moves to output; no input is accepted because in_ready is 0.
REQ-025 Output empty and skid empty: an accepted input loads the output register directly.
REQ-026 flush has priority over any handshake in the same cycle.
- Next cycle: out_valid=0, skid empty, in_ready=1.
- An input offered during the flush cycle is discarded.
REQ-027 The decode path is combinational ahead of the registers; no combinational path runs from out_ready to in_ready.

Reset
REQ-028 While reset=1 at an edge, the following values result:
- out_valid=0, in_ready=1, imm_ext=0, err=0.
- skid_valid=0, skid data=0.
REQ-029 reset overrides flush and all handshakes.
REQ-030 Reset mid-stall discards both held entries.
REQ-031 The first transfer after reset is possible in the cycle after reset deasserts.

Structure
REQ-032 A shared package shall hold:
- imm_src_e enum: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR, IMM_SHAMT, IMM_ILL.
- Constant INST_W_DEF = 25.
REQ-033 The decode shall be one combinational sub-module imm_decode (inst, imm_src -> imm, illegal), parametrised by XLEN.
REQ-034 The pipeline/skid logic lives in imm_gen_pipe.

Verification
REQ-035 I-type:
- Stimulus: inst=25'b0000000010100000000001000, imm_src=000, out_ready=1.
- Response: next cycle out_valid=1, imm_ext=32'h0000000A, err=0.
REQ-036 Sign/zero extension at XLEN=64:
- U-type with inst[24:5]=20'h80000 -> imm_ext=64'hFFFFFFFF80000000.
- shamt with inst[18:13]=6'h3F -> imm_ext=64'h3F.
REQ-037 Back-pressure:
- Stimulus: out_ready=0, three back-to-back offers A, B, C.
- Response: A in output, B in skid, in_ready=0 so C waits.
- Then out_ready=1: order is A, B, C; imm_ext stays stable while stalled.
REQ-038 Streaming:
- Stimulus: in_valid=1 and out_ready=1 for 8 cycles with distinct B-types.
- Response: 8 results at one per cycle, 1-cycle latency, in_ready always 1.
REQ-039 Illegal format:
- Stimulus: imm_src=111.
- Response: imm_ext=0, err=1.
- The following legal entry has err=0.
REQ-040 Flush and reset mid-operation:
- With both registers full, pulse flush with in_valid=1: next cycle out_valid=0, in_ready=1, no output appears.
- Repeat with reset instead of flush: same result, and all outputs are 0.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate-generation pipeline: format encodings
// and the default instruction field width.
package imm_gen_pipe_pkg;

    // Immediate format select, encoded as the 3-bit imm_src field.
    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_CSR   = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ILL   = 3'd7
    } imm_src_e;

    // The instruction field carries instr[31:7], so bit 24 is instr[31].
    localparam int INST_W_DEF = 25;

endpackage : imm_gen_pipe_pkg

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: extracts and extends the immediate for the
// selected format and flags the reserved encoding as illegal.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int INST_W = INST_W_DEF
) (
    input  logic [INST_W-1:0] inst,
    input  logic [2:0]        imm_src,
    output logic [XLEN-1:0]   imm,
    output logic              illegal
);

    logic [31:0] raw;       // 32-bit form of the immediate
    logic        sign_ext;  // widen raw by sign (1) or by zero (0)

    // Assemble the 32-bit immediate for the format, then widen it to XLEN.
    // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        raw      = '0;
        sign_ext = 1'b0;
        illegal  = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I: begin
                raw      = {{20{inst[24]}}, inst[24:13]};
                sign_ext = 1'b1;
            end
            IMM_S: begin
                raw      = {{20{inst[24]}}, inst[24:18], inst[4:0]};
                sign_ext = 1'b1;
            end
            IMM_B: begin
                raw      = {{19{inst[24]}}, inst[24], inst[0], inst[23:18], inst[4:1], 1'b0};
                sign_ext = 1'b1;
            end
            IMM_U: begin
                raw      = {inst[24:5], 12'b0};
                sign_ext = 1'b1;
            end
            IMM_J: begin
                raw      = {{11{inst[24]}}, inst[24], inst[12:5], inst[13], inst[23:14], 1'b0};
                sign_ext = 1'b1;
            end
            IMM_CSR: begin
                raw = {27'b0, inst[12:8]};
            end
            IMM_SHAMT: begin
                // RV64 shifts take a 6-bit amount, RV32 only 5 bits.
                raw = (XLEN == 64) ? {26'b0, inst[18:13]} : {27'b0, inst[17:13]};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        imm = sign_ext ? XLEN'($signed(raw)) : XLEN'(raw);
    end

endmodule : imm_decode

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered output stage and one skid entry, so
// in_ready is a pure register and never depends combinationally on out_ready.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    input  logic [2:0]        imm_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm_ext,
    output logic              err
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic            out_err_q,   out_err_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic            skid_err_q,   skid_err_d;

    logic in_fire;
    logic out_free;

    imm_decode #(
        .XLEN   (XLEN),
        .INST_W (INST_W)
    ) u_decode (
        .inst    (inst),
        .imm_src (imm_src),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    // The output register can take a new entry when it is empty or draining.
    assign out_free = !out_valid_q || out_ready;

    // Next-state: refill the output from skid first, else from the input; a stalled accept goes to skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no input competes with the skid entry.
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_err_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_err_d   = dec_ill;
        end
    end

    // State registers with synchronous reset; reset outranks flush and handshakes.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data registers are reset too, so the outputs and skid contents read as zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign imm_ext   = out_imm_q;
    assign err       = out_err_q;

endmodule : imm_gen_pipe

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share
// the same stimulus; expected values are hand-computed constants.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [24:0] inst;
    logic [2:0]  imm_src;
    logic        out_ready;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;

    int n_checks = 0;
    int n_fail   = 0;

    imm_gen_pipe #(.XLEN(32), .INST_W(25)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .inst      (inst),
        .imm_src   (imm_src),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .imm_ext   (imm32),
        .err       (err32)
    );

    imm_gen_pipe #(.XLEN(64), .INST_W(25)) dut64 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .inst      (inst),
        .imm_src   (imm_src),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .imm_ext   (imm64),
        .err       (err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Format table: inst, imm_src, expected XLEN=32 / XLEN=64 result, expected err.
    localparam int NF = 12;
    logic [24:0] f_inst [NF];
    logic [2:0]  f_src  [NF];
    logic [31:0] f_e32  [NF];
    logic [63:0] f_e64  [NF];
    logic        f_err  [NF];

    initial begin
        f_inst = '{25'h0014008, 25'h1FFE000, 25'h1000005, 25'h00C000D,
                   25'h02468A0, 25'h1000000, 25'h100A020, 25'h1001F00,
                   25'h107E000, 25'h1FFFFFF, 25'h0014008, 25'h0014008};
        f_src  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5,
                   3'd6, 3'd7, 3'd0, 3'd0};
        f_e32  = '{32'h0000000A, 32'hFFFFFFFF, 32'hFFFFF805, 32'h0000086C,
                   32'h12345000, 32'h80000000, 32'hFFF01804, 32'h0000001F,
                   32'h0000001F, 32'h00000000, 32'h0000000A, 32'h0000000A};
        f_e64  = '{64'h000000000000000A, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFF805,
                   64'h000000000000086C, 64'h0000000012345000, 64'hFFFFFFFF80000000,
                   64'hFFFFFFFFFFF01804, 64'h000000000000001F, 64'h000000000000003F,
                   64'h0000000000000000, 64'h000000000000000A, 64'h000000000000000A};
        f_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b1, 1'b0, 1'b0};
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst      = '0;
        imm_src   = 3'd0;
        out_ready = 1'b1;
        #1;
        tick();
        tick();

        // Reset state.
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_in_ready",  64'(in_ready32),  64'd1);
        check("rst_imm",       64'(imm32),       64'd0);
        check("rst_err",       64'(err32),       64'd0);
        check("rst_imm64",     imm64,            64'd0);

        // Formats, streamed with out_ready high; first offer is the cycle after reset drops.
        reset = 1'b0;
        for (int i = 0; i < NF; i++) begin
            in_valid = 1'b1;
            inst     = f_inst[i];
            imm_src  = f_src[i];
            tick();
            check($sformatf("fmt%0d_valid", i),    64'(out_valid32), 64'd1);
            check($sformatf("fmt%0d_imm32", i),    64'(imm32),       64'(f_e32[i]));
            check($sformatf("fmt%0d_imm64", i),    imm64,            f_e64[i]);
            check($sformatf("fmt%0d_err", i),      64'(err32),       64'(f_err[i]));
            check($sformatf("fmt%0d_in_ready", i), 64'(in_ready32),  64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("fmt_drain_valid", 64'(out_valid32), 64'd0);

        // Back-pressure: A to output, B to skid, C waits; then drain in order.
        out_ready = 1'b0;
        imm_src   = 3'd0;
        in_valid  = 1'b1;
        inst      = 25'h0002000;   // A -> imm 1
        tick();
        check("bp_a_valid",    64'(out_valid32), 64'd1);
        check("bp_a_imm",      64'(imm32),       64'd1);
        check("bp_a_in_ready", 64'(in_ready32),  64'd1);
        inst = 25'h0004000;        // B -> imm 2
        tick();
        check("bp_b_in_ready", 64'(in_ready32),  64'd0);
        check("bp_hold_imm1",  64'(imm32),       64'd1);
        inst = 25'h0006000;        // C -> imm 3
        tick();
        check("bp_c_in_ready", 64'(in_ready32),  64'd0);
        check("bp_hold_imm2",  64'(imm32),       64'd1);
        check("bp_hold_valid", 64'(out_valid32), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_out_b",      64'(imm32),       64'd2);
        check("bp_b_valid",    64'(out_valid32), 64'd1);
        check("bp_reready",    64'(in_ready32),  64'd1);
        tick();
        check("bp_out_c",      64'(imm32),       64'd3);
        check("bp_c_valid",    64'(out_valid32), 64'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", 64'(out_valid32), 64'd0);

        // Streaming: 8 distinct B-types, one result per cycle.
        imm_src  = 3'd2;
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            inst = 25'(2 * i);
            tick();
            check($sformatf("str%0d_valid", i),    64'(out_valid32), 64'd1);
            check($sformatf("str%0d_imm", i),      64'(imm32),       64'(2 * i));
            check($sformatf("str%0d_in_ready", i), 64'(in_ready32),  64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("str_drain_valid", 64'(out_valid32), 64'd0);

        // Flush with both registers full and an input offered.
        imm_src   = 3'd0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst      = 25'h0002000;
        tick();
        inst = 25'h0004000;
        tick();
        check("fl_full", 64'(in_ready32), 64'd0);
        flush = 1'b1;
        inst  = 25'h0006000;
        tick();
        check("fl_valid",    64'(out_valid32), 64'd0);
        check("fl_in_ready", 64'(in_ready32),  64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_no_output", 64'(out_valid32), 64'd0);

        // Flush discards an input accepted-looking offer while in_ready is high.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst      = 25'h0002000;
        tick();
        flush = 1'b1;
        inst  = 25'h0004000;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("fl1_valid",    64'(out_valid32), 64'd0);
        check("fl1_in_ready", 64'(in_ready32),  64'd1);

        // Reset mid-stall with both registers full; reset also outranks flush.
        in_valid = 1'b1;
        inst     = 25'h1FFE000;    // imm all ones
        tick();
        inst = 25'h0004000;
        tick();
        check("rs_full", 64'(in_ready32), 64'd0);
        reset = 1'b1;
        flush = 1'b1;
        inst  = 25'h0006000;
        tick();
        check("rs_valid",    64'(out_valid32), 64'd0);
        check("rs_in_ready", 64'(in_ready32),  64'd1);
        check("rs_imm",      64'(imm32),       64'd0);
        check("rs_err",      64'(err32),       64'd0);
        check("rs_imm64",    imm64,            64'd0);
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rs_no_output", 64'(out_valid32), 64'd0);

        // First transfer after reset.
        in_valid = 1'b1;
        inst     = 25'h0014008;
        tick();
        check("post_rs_valid", 64'(out_valid32), 64'd1);
        check("post_rs_imm",   64'(imm32),       64'h0A);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imm_gen_pipe
